// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types for the pipelined decode/control block.
//   - RV opcode constants
//   - enums for immediate format, result source, ALU op, ALU A source, forward select
//   - ctrl_t: control bundle carried down the D->E->M->W registers
//   - CTRL_BUBBLE: the all-inactive bundle loaded on reset, flush and stall
package ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'd3;
   localparam logic [6:0] OP_IMM    = 7'd19;
   localparam logic [6:0] OP_IMM32  = 7'd27;
   localparam logic [6:0] OP_JALR   = 7'd103;
   localparam logic [6:0] OP_STORE  = 7'd35;
   localparam logic [6:0] OP_OP     = 7'd51;
   localparam logic [6:0] OP_OP32   = 7'd59;
   localparam logic [6:0] OP_BRANCH = 7'd99;
   localparam logic [6:0] OP_JAL    = 7'd111;
   localparam logic [6:0] OP_AUIPC  = 7'd23;
   localparam logic [6:0] OP_LUI    = 7'd55;

   typedef enum logic [2:0] {IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010,
                             IMM_J = 3'b011, IMM_U = 3'b100} imm_src_t;
   typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10} result_src_t;
   typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10} alu_op_t;
   typedef enum logic [1:0] {ASRC_RS1 = 2'b00, ASRC_PC = 2'b01, ASRC_ZERO = 2'b10} a_src_t;
   typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10} fwd_t;

   typedef struct packed {
      logic        reg_write;
      result_src_t result_src;
      logic        mem_write;
      logic        jump;
      logic        jalr;
      logic        branch;
      logic        alu_src;
      a_src_t      a_src;
      alu_op_t     alu_op;
      logic        is_word;
      logic        illegal;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = ctrl_t'{1'b0, RES_ALU, 1'b0, 1'b0, 1'b0, 1'b0,
                                           1'b0, ASRC_RS1, ALUOP_ADD, 1'b0, 1'b0};

   // Only loads take their result from memory, so that pair identifies a load.
   function automatic logic is_load(input ctrl_t c);
      return c.reg_write && (c.result_src == RES_MEM);
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational opcode -> control bundle.
//   opcode   in   7  instruction[6:0]
//   valid    in   1  0 forces a bubble bundle
//   ctrl     out     decoded ctrl_t
//   imm_src  out     immediate format for the datapath
//   use_rs1  out  1  instruction reads rs1 (feeds load-use detection)
//   use_rs2  out  1  instruction reads rs2
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter bit RV64 = 1'b1
) (
   input  logic [6:0] opcode,
   input  logic       valid,
   output ctrl_t      ctrl,
   output imm_src_t   imm_src,
   output logic       use_rs1,
   output logic       use_rs2
);

   always_comb begin
      ctrl    = CTRL_BUBBLE;
      imm_src = IMM_I;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      if (valid) begin
         case (opcode)
            OP_LOAD: begin
               ctrl.reg_write = 1'b1; ctrl.result_src = RES_MEM; ctrl.alu_src = 1'b1;
               use_rs1 = 1'b1;
            end
            OP_IMM: begin
               ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALUOP_FUNCT;
               use_rs1 = 1'b1;
            end
            OP_IMM32: begin
               if (RV64) begin
                  ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALUOP_FUNCT;
                  ctrl.is_word = 1'b1; use_rs1 = 1'b1;
               end else ctrl.illegal = 1'b1;
            end
            OP_JALR: begin
               ctrl.reg_write = 1'b1; ctrl.result_src = RES_PC4; ctrl.jump = 1'b1;
               ctrl.jalr = 1'b1; ctrl.alu_src = 1'b1; use_rs1 = 1'b1;
            end
            OP_STORE: begin
               ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1; imm_src = IMM_S;
               use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_OP: begin
               ctrl.reg_write = 1'b1; ctrl.alu_op = ALUOP_FUNCT;
               use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_OP32: begin
               if (RV64) begin
                  ctrl.reg_write = 1'b1; ctrl.alu_op = ALUOP_FUNCT; ctrl.is_word = 1'b1;
                  use_rs1 = 1'b1; use_rs2 = 1'b1;
               end else ctrl.illegal = 1'b1;
            end
            OP_BRANCH: begin
               ctrl.branch = 1'b1; ctrl.alu_op = ALUOP_SUB; imm_src = IMM_B;
               use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_JAL: begin
               ctrl.reg_write = 1'b1; ctrl.result_src = RES_PC4; ctrl.jump = 1'b1;
               imm_src = IMM_J;
            end
            OP_AUIPC: begin
               ctrl.reg_write = 1'b1; ctrl.a_src = ASRC_PC; ctrl.alu_src = 1'b1;
               imm_src = IMM_U;
            end
            OP_LUI: begin
               ctrl.reg_write = 1'b1; ctrl.a_src = ASRC_ZERO; ctrl.alu_src = 1'b1;
               imm_src = IMM_U;
            end
            default: ctrl.illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: decodes the D-stage instruction and carries its control
// through E/M/W registers, with load-use stall, redirect flush and EX forwarding.
//   clk, rst                         clock, synchronous active-high reset
//   inst_d, valid_d                  instruction in D and its valid flag
//   branch_cond_e                    branch compare result for the E instruction
//   imm_src_d                        immediate format (combinational from D)
//   stall_f, stall_d, flush_d        front-end hold / clear
//   pc_src_e, jalr_e                 redirect and its target select
//   alu_src_e .. is_word_e           E-stage datapath control
//   fwd_a_e, fwd_b_e                 operand forward selects (10 M, 01 W)
//   mem_write_m, funct3_m            M-stage control
//   reg_write_w .. illegal_w         W-stage control
module decode_ctrl_pipe
   import ctrl_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter bit RV64   = 1'b1,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       inst_d,
   input  logic              valid_d,
   input  logic              branch_cond_e,
   output logic [2:0]        imm_src_d,
   output logic              stall_f,
   output logic              stall_d,
   output logic              flush_d,
   output logic              pc_src_e,
   output logic              jalr_e,
   output logic              alu_src_e,
   output logic [1:0]        alu_a_src_e,
   output logic [1:0]        alu_op_e,
   output logic [2:0]        funct3_e,
   output logic              funct7b5_e,
   output logic              is_word_e,
   output logic [1:0]        fwd_a_e,
   output logic [1:0]        fwd_b_e,
   output logic              mem_write_m,
   output logic [2:0]        funct3_m,
   output logic              reg_write_w,
   output logic [1:0]        result_src_w,
   output logic [REG_AW-1:0] rd_w,
   output logic              illegal_w
);

   if (XLEN == 32 && RV64) begin : g_bad_cfg
      $error("decode_ctrl_pipe: RV64 word ops need XLEN=64");
   end

   ctrl_t             ctrl_d, ctrl_e;
   imm_src_t          imm_src;
   logic              use_rs1, use_rs2;
   logic [REG_AW-1:0] rd_d, rs1_d, rs2_d;
   logic [REG_AW-1:0] rd_e, rs1_e, rs2_e, rd_m;
   logic              reg_write_m, illegal_m;
   result_src_t       result_src_m;
   logic              lu_hazard, redirect;
   logic              unused_inst;

   assign unused_inst = ^{inst_d[31], inst_d[29:25]};

   ctrl_decode #(.RV64(RV64)) u_dec (
      .opcode (inst_d[6:0]),
      .valid  (valid_d),
      .ctrl   (ctrl_d),
      .imm_src(imm_src),
      .use_rs1(use_rs1),
      .use_rs2(use_rs2)
   );

   assign imm_src_d = imm_src;
   assign rd_d  = REG_AW'(inst_d[11:7]);
   assign rs1_d = REG_AW'(inst_d[19:15]);
   assign rs2_d = REG_AW'(inst_d[24:20]);

   // Hazard unit: both terms look only at current E/D contents.
   assign lu_hazard = is_load(ctrl_e) && (rd_e != '0) &&
                      ((use_rs1 && rs1_d == rd_e) || (use_rs2 && rs2_d == rd_e));
   assign redirect  = ctrl_e.jump || (ctrl_e.branch && branch_cond_e);
   assign pc_src_e  = redirect;
   assign flush_d   = redirect;
   // A redirect overrides the stall: the stalled D instruction is wrong-path anyway.
   assign stall_f   = lu_hazard && !redirect;
   assign stall_d   = lu_hazard && !redirect;

   // D -> E: bubble on reset, redirect or load-use; invalid D carries zeroed fields.
   always_ff @(posedge clk) begin
      if (rst || redirect || lu_hazard || !valid_d) begin
         ctrl_e     <= CTRL_BUBBLE;
         rd_e       <= '0;
         rs1_e      <= '0;
         rs2_e      <= '0;
         funct3_e   <= '0;
         funct7b5_e <= 1'b0;
      end else begin
         ctrl_e     <= ctrl_d;
         rd_e       <= rd_d;
         rs1_e      <= rs1_d;
         rs2_e      <= rs2_d;
         funct3_e   <= inst_d[14:12];
         funct7b5_e <= inst_d[30];
      end
   end

   assign jalr_e      = ctrl_e.jalr;
   assign alu_src_e   = ctrl_e.alu_src;
   assign alu_a_src_e = ctrl_e.a_src;
   assign alu_op_e    = ctrl_e.alu_op;
   assign is_word_e   = ctrl_e.is_word;

   // E -> M -> W advance every cycle, so a stalled load drains.
   always_ff @(posedge clk) begin
      if (rst) begin
         reg_write_m  <= 1'b0;
         result_src_m <= RES_ALU;
         mem_write_m  <= 1'b0;
         illegal_m    <= 1'b0;
         rd_m         <= '0;
         funct3_m     <= '0;
         reg_write_w  <= 1'b0;
         result_src_w <= '0;
         illegal_w    <= 1'b0;
         rd_w         <= '0;
      end else begin
         reg_write_m  <= ctrl_e.reg_write;
         result_src_m <= ctrl_e.result_src;
         mem_write_m  <= ctrl_e.mem_write;
         illegal_m    <= ctrl_e.illegal;
         rd_m         <= rd_e;
         funct3_m     <= funct3_e;
         reg_write_w  <= reg_write_m;
         result_src_w <= result_src_m;
         illegal_w    <= illegal_m;
         rd_w         <= rd_m;
      end
   end

   // Forwarding: M is younger than W so it wins; x0 never forwards.
   always_comb begin
      fwd_a_e = FWD_RF;
      fwd_b_e = FWD_RF;
      if (reg_write_m && rd_m != '0 && rd_m == rs1_e)      fwd_a_e = FWD_M;
      else if (reg_write_w && rd_w != '0 && rd_w == rs1_e) fwd_a_e = FWD_W;
      if (reg_write_m && rd_m != '0 && rd_m == rs2_e)      fwd_b_e = FWD_M;
      else if (reg_write_w && rd_w != '0 && rd_w == rs2_e) fwd_b_e = FWD_W;
   end

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: an RV64 and an RV32 instance share stimulus; each
// is compared every cycle against an instruction-level pipeline model, with a
// fetch emulator honouring stall/flush. Directed sequences add event-count checks.
module tb_decode_ctrl_pipe;

   typedef struct packed {
      bit       rw;  bit [1:0] rsrc; bit mw, jump, jalr, br, asrc;
      bit [1:0] asel, aop; bit word, ill;
      bit [4:0] rd, rs1, rs2; bit [2:0] f3; bit f7;
   } rec_t;

   typedef struct packed {
      bit [2:0] imm; bit stall_f, stall_d, flush, pc_src, jalr, alu_src;
      bit [1:0] asel, aop; bit [2:0] f3e; bit f7e, word;
      bit [1:0] fa, fb; bit mw; bit [2:0] f3m; bit rw; bit [1:0] rsrc;
      bit [4:0] rdw; bit ill;
   } out_t;

   logic clk = 1'b0, rst = 1'b1, valid_d = 1'b0, branch_cond_e = 1'b0;
   logic [31:0] inst_d = '0;
   always #5 clk = ~clk;

   logic [2:0] imm_o[2], f3e_o[2], f3m_o[2];
   logic       stf_o[2], std_o[2], fl_o[2], pcs_o[2], jr_o[2], as_o[2], f7_o[2], wd_o[2];
   logic       mw_o[2], rw_o[2], il_o[2];
   logic [1:0] asel_o[2], aop_o[2], fa_o[2], fb_o[2], rs_o[2];
   logic [4:0] rd_o[2];
   out_t       obs[2];

   decode_ctrl_pipe #(.XLEN(64), .RV64(1'b1), .REG_AW(5)) dut (
      .clk(clk), .rst(rst), .inst_d(inst_d), .valid_d(valid_d), .branch_cond_e(branch_cond_e),
      .imm_src_d(imm_o[0]), .stall_f(stf_o[0]), .stall_d(std_o[0]), .flush_d(fl_o[0]),
      .pc_src_e(pcs_o[0]), .jalr_e(jr_o[0]), .alu_src_e(as_o[0]), .alu_a_src_e(asel_o[0]),
      .alu_op_e(aop_o[0]), .funct3_e(f3e_o[0]), .funct7b5_e(f7_o[0]), .is_word_e(wd_o[0]),
      .fwd_a_e(fa_o[0]), .fwd_b_e(fb_o[0]), .mem_write_m(mw_o[0]), .funct3_m(f3m_o[0]),
      .reg_write_w(rw_o[0]), .result_src_w(rs_o[0]), .rd_w(rd_o[0]), .illegal_w(il_o[0]));

   decode_ctrl_pipe #(.XLEN(32), .RV64(1'b0), .REG_AW(5)) dut32 (
      .clk(clk), .rst(rst), .inst_d(inst_d), .valid_d(valid_d), .branch_cond_e(branch_cond_e),
      .imm_src_d(imm_o[1]), .stall_f(stf_o[1]), .stall_d(std_o[1]), .flush_d(fl_o[1]),
      .pc_src_e(pcs_o[1]), .jalr_e(jr_o[1]), .alu_src_e(as_o[1]), .alu_a_src_e(asel_o[1]),
      .alu_op_e(aop_o[1]), .funct3_e(f3e_o[1]), .funct7b5_e(f7_o[1]), .is_word_e(wd_o[1]),
      .fwd_a_e(fa_o[1]), .fwd_b_e(fb_o[1]), .mem_write_m(mw_o[1]), .funct3_m(f3m_o[1]),
      .reg_write_w(rw_o[1]), .result_src_w(rs_o[1]), .rd_w(rd_o[1]), .illegal_w(il_o[1]));

   for (genvar g = 0; g < 2; g++) begin : g_obs
      assign obs[g] = {imm_o[g], stf_o[g], std_o[g], fl_o[g], pcs_o[g], jr_o[g], as_o[g],
                       asel_o[g], aop_o[g], f3e_o[g], f7_o[g], wd_o[g], fa_o[g], fb_o[g],
                       mw_o[g], f3m_o[g], rw_o[g], rs_o[g], rd_o[g], il_o[g]};
   end

   int   n_vec = 0, n_err = 0;
   rec_t se[2], sm[2], sw[2];
   logic [31:0] q[$];
   logic [31:0] cur_inst = '0;
   bit   cur_valid = 1'b0, rnd = 1'b0, rst_req = 1'b1, warm = 1'b0, check_zero = 1'b0;
   int   c_stall, c_flush, c_fwd01, c_fwd22, c_jal, c_jalr, c_ill64, c_ill32, c_rd7, c_rd9;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s @%0t: got %h want %h", tag, $time, got, want);
      end
   endtask

   // Spec-level decode: membership flags per opcode class.
   function automatic void mdec(input logic [31:0] in, input bit v, input bit rv64,
                                output rec_t r, output bit u1, output bit u2,
                                output bit [2:0] imm);
      bit [6:0] op;
      bit ld, oi, oiw, jr, st, rr, rrw, br, jl, au, lu, known;
      op  = in[6:0];
      ld  = op == 7'd3;  oi = op == 7'd19; oiw = (op == 7'd27) && rv64; jr = op == 7'd103;
      st  = op == 7'd35; rr = op == 7'd51; rrw = (op == 7'd59) && rv64; br = op == 7'd99;
      jl  = op == 7'd111; au = op == 7'd23; lu = op == 7'd55;
      known = ld | oi | oiw | jr | st | rr | rrw | br | jl | au | lu;
      r = '0; u1 = 1'b0; u2 = 1'b0; imm = 3'd0;
      if (!v) return;
      r.rd = in[11:7]; r.rs1 = in[19:15]; r.rs2 = in[24:20]; r.f3 = in[14:12]; r.f7 = in[30];
      r.rw   = ld | oi | oiw | jr | rr | rrw | jl | au | lu;
      r.rsrc = (jr | jl) ? 2'd2 : (ld ? 2'd1 : 2'd0);
      r.mw   = st; r.jump = jr | jl; r.jalr = jr; r.br = br;
      r.asrc = ld | oi | oiw | jr | st | au | lu;
      r.asel = au ? 2'd1 : (lu ? 2'd2 : 2'd0);
      r.aop  = br ? 2'd1 : ((oi | oiw | rr | rrw) ? 2'd2 : 2'd0);
      r.word = oiw | rrw; r.ill = !known;
      u1  = known && !(lu | au | jl);
      u2  = rr | rrw | st | br;
      imm = st ? 3'd1 : br ? 3'd2 : jl ? 3'd3 : (au | lu) ? 3'd4 : 3'd0;
   endfunction

   function automatic bit [1:0] fw(input bit [4:0] rs, input rec_t m, input rec_t w);
      if (m.rw && m.rd != 0 && m.rd == rs) return 2'b10;
      if (w.rw && w.rd != 0 && w.rd == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [31:0] mk(input bit [6:0] op, input bit [4:0] rd, input bit [4:0] rs1,
                                      input bit [4:0] rs2, input bit [2:0] f3, input bit b30);
      return {1'b0, b30, 5'b0, rs2, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] rand_inst();
      bit [6:0] ops[12] = '{7'd3, 7'd19, 7'd27, 7'd103, 7'd35, 7'd51, 7'd59, 7'd99,
                            7'd111, 7'd23, 7'd55, 7'd127};
      logic [31:0] r;
      int k;
      r = $urandom;
      k = $urandom_range(0, 12);
      r[6:0]   = (k == 12) ? 7'($urandom) : ops[k];
      r[11:7]  = 5'($urandom_range(0, 3));
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      return r;
   endfunction

   task automatic fetch();
      if (q.size() > 0) begin cur_inst = q.pop_front(); cur_valid = 1'b1; end
      else if (rnd)     begin cur_inst = rand_inst(); cur_valid = ($urandom_range(0, 9) != 0); end
      else              begin cur_inst = '0; cur_valid = 1'b0; end
   endtask

   task automatic clr_cnt();
      c_stall = 0; c_flush = 0; c_fwd01 = 0; c_fwd22 = 0; c_jal = 0; c_jalr = 0;
      c_ill64 = 0; c_ill32 = 0; c_rd7 = 0; c_rd9 = 0;
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) begin
         rec_t nx[2];
         bit   redir0, stl0;
         @(negedge clk);
         if (rnd) begin
            rst = ($urandom_range(0, 49) == 0);
            branch_cond_e = 1'($urandom_range(0, 1));
         end else begin
            rst = rst_req;
            branch_cond_e = 1'b1;
         end
         inst_d = cur_inst; valid_d = cur_valid;
         #1;
         redir0 = 1'b0; stl0 = 1'b0;
         for (int v = 0; v < 2; v++) begin
            rec_t d; bit u1, u2, hz, rd_r; bit [2:0] imm; out_t ex;
            mdec(inst_d, valid_d, v == 0, d, u1, u2, imm);
            hz   = se[v].rw && se[v].rsrc == 2'd1 && se[v].rd != 0 &&
                   ((u1 && inst_d[19:15] == se[v].rd) || (u2 && inst_d[24:20] == se[v].rd));
            rd_r = se[v].jump || (se[v].br && branch_cond_e);
            ex = '0;
            ex.imm = imm; ex.stall_f = hz && !rd_r; ex.stall_d = hz && !rd_r;
            ex.flush = rd_r; ex.pc_src = rd_r; ex.jalr = se[v].jalr; ex.alu_src = se[v].asrc;
            ex.asel = se[v].asel; ex.aop = se[v].aop; ex.f3e = se[v].f3; ex.f7e = se[v].f7;
            ex.word = se[v].word;
            ex.fa = fw(se[v].rs1, sm[v], sw[v]); ex.fb = fw(se[v].rs2, sm[v], sw[v]);
            ex.mw = sm[v].mw; ex.f3m = sm[v].f3;
            ex.rw = sw[v].rw; ex.rsrc = sw[v].rsrc; ex.rdw = sw[v].rd; ex.ill = sw[v].ill;
            if (warm) chk(v == 0 ? "outs_rv64" : "outs_rv32", 64'(obs[v]), 64'(ex));
            nx[v] = (rst || rd_r || hz) ? '0 : d;
            if (v == 0) begin redir0 = rd_r; stl0 = hz && !rd_r; end
         end
         if (warm && check_zero) begin
            chk("rst_zero_rv64", 64'(obs[0]), 64'd0);
            chk("rst_zero_rv32", 64'(obs[1]), 64'd0);
            check_zero = 1'b0;
         end
         c_stall += int'(stf_o[0] && std_o[0]);
         c_flush += int'(fl_o[0]);
         c_fwd01 += int'(fa_o[0] == 2'b01);
         c_fwd22 += int'(fa_o[0] == 2'b10 && fb_o[0] == 2'b10);
         c_jal   += int'(rw_o[0] && rs_o[0] == 2'b10 && rd_o[0] == 5'd1);
         c_jalr  += int'(jr_o[0]);
         c_ill64 += int'(il_o[0]);
         c_ill32 += int'(il_o[1]);
         c_rd7   += int'(rw_o[0] && rd_o[0] == 5'd7);
         c_rd9   += int'(rw_o[0] && rd_o[0] == 5'd9);
         @(posedge clk);
         for (int v = 0; v < 2; v++) begin
            if (rst) begin se[v] = '0; sm[v] = '0; sw[v] = '0; end
            else begin sw[v] = sm[v]; sm[v] = se[v]; se[v] = nx[v]; end
         end
         // Fetch emulation: flush empties IF/ID for a cycle, stall holds it.
         if (rst) fetch();
         else if (redir0) begin cur_valid = 1'b0; cur_inst = '0; end
         else if (!stl0) fetch();
      end
   endtask

   task automatic phase(input int n);
      clr_cnt();
      fetch();
      run(n);
   endtask

   initial begin
      for (int v = 0; v < 2; v++) begin se[v] = '0; sm[v] = '0; sw[v] = '0; end
      rst_req = 1'b1;
      run(2);
      rst_req = 1'b0; warm = 1'b1; check_zero = 1'b1;
      run(2);

      // load-use: one stall, then W->E forward
      q.push_back(mk(7'd3, 5'd5, 5'd1, 5'd0, 3'd2, 1'b0));
      q.push_back(mk(7'd51, 5'd6, 5'd5, 5'd2, 3'd0, 1'b0));
      phase(8);
      chk("lu_stall_cycles", 64'(c_stall), 64'd1);
      chk("lu_fwd_w", 64'(c_fwd01), 64'd1);

      // back-to-back ALU: M->E forward on both operands
      q.push_back(mk(7'd51, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0));
      q.push_back(mk(7'd51, 5'd4, 5'd3, 5'd3, 3'd0, 1'b1));
      phase(8);
      chk("alu_fwd_m", 64'(c_fwd22), 64'd1);
      chk("alu_no_stall", 64'(c_stall), 64'd0);

      // taken branch: one flush, wrong-path x7 never writes back
      q.push_back(mk(7'd99, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0));
      q.push_back(mk(7'd19, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0));
      q.push_back(mk(7'd19, 5'd8, 5'd0, 5'd0, 3'd0, 1'b0));
      phase(9);
      chk("br_flush", 64'(c_flush), 64'd1);
      chk("br_wrong_path", 64'(c_rd7), 64'd0);

      // jal x1 / jalr x0,0(x1)
      q.push_back(mk(7'd111, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0));
      q.push_back(mk(7'd19, 5'd10, 5'd0, 5'd0, 3'd0, 1'b0));
      q.push_back(mk(7'd103, 5'd0, 5'd1, 5'd0, 3'd0, 1'b0));
      q.push_back(mk(7'd19, 5'd11, 5'd0, 5'd0, 3'd0, 1'b0));
      phase(10);
      chk("jal_wb_pc4", 64'(c_jal), 64'd1);
      chk("jalr_e", 64'(c_jalr), 64'd1);

      // 0x7F illegal everywhere, addw illegal only without RV64
      q.push_back(mk(7'd127, 5'd12, 5'd1, 5'd2, 3'd0, 1'b0));
      q.push_back(mk(7'd59, 5'd13, 5'd1, 5'd2, 3'd0, 1'b0));
      phase(8);
      chk("illegal_rv64", 64'(c_ill64), 64'd1);
      chk("illegal_rv32", 64'(c_ill32), 64'd2);

      // reset while a load sits in M
      q.push_back(mk(7'd3, 5'd9, 5'd1, 5'd0, 3'd3, 1'b0));
      phase(2);
      rst_req = 1'b1;
      run(1);
      rst_req = 1'b0; check_zero = 1'b1;
      run(5);
      chk("rst_load_dropped", 64'(c_rd9), 64'd0);

      // random traffic
      rnd = 1'b1;
      run(3000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
